// File: rtl/blk_stage_pipe.sv
// LANES-wide capture pipeline of DEPTH stages feeding a registered bitwise combine stage, valid/ready throughout.
// Optional BLK_STAGE_PIPE_CNT_EN adds a 32-bit count of output handshakes on beat_count.
module blk_stage_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
`ifdef BLK_STAGE_PIPE_CNT_EN
  ,
  output logic [31:0]            beat_count
`endif
);

  logic [DEPTH-1:0]       s_valid;
  logic [LANES*WIDTH-1:0] s_data [DEPTH];
  logic [1:0]             s_mode [DEPTH];
  logic                   r_valid;
  logic [WIDTH-1:0]       r_data;

  // can_load[DEPTH] belongs to the result slot
  logic [DEPTH:0]         can_load;
  logic [WIDTH-1:0]       comb_res;

  // A slot can take new content unless it and everything downstream is full and stalled.
  always_comb begin
    logic full;
    can_load = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      full = r_valid;
      for (int j = 0; j < DEPTH; j++) begin
        if (j >= i) full = full & s_valid[j];
      end
      can_load[i] = ~full | out_ready;
    end
  end

  assign in_ready  = ~rst & can_load[0];
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_comb begin
    logic [WIDTH-1:0] acc_and, acc_or, acc_xor, lane;
    acc_and = '1;
    acc_or  = '0;
    acc_xor = '0;
    for (int k = 0; k < LANES; k++) begin
      lane    = s_data[DEPTH-1][k*WIDTH +: WIDTH];
      acc_and = acc_and & lane;
      acc_or  = acc_or  | lane;
      acc_xor = acc_xor ^ lane;
    end
    case (s_mode[DEPTH-1])
      2'b00:   comb_res = acc_and;
      2'b01:   comb_res = acc_or;
      2'b10:   comb_res = acc_xor;
      default: comb_res = s_data[DEPTH-1][WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (can_load[0]) s_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        if (can_load[i]) s_valid[i] <= s_valid[i-1];
      end
      if (can_load[DEPTH]) begin
        r_valid <= s_valid[DEPTH-1];
        if (s_valid[DEPTH-1]) r_data <= comb_res;
      end
    end
  end

  // Payload carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (can_load[0] && in_valid) begin
      s_data[0] <= in_data;
      s_mode[0] <= mode;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (can_load[i] && s_valid[i-1]) begin
        s_data[i] <= s_data[i-1];
        s_mode[i] <= s_mode[i-1];
      end
    end
  end

`ifdef BLK_STAGE_PIPE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                        beat_count <= '0;
    else if (r_valid && out_ready)  beat_count <= beat_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_blk_stage_pipe.sv
// Randomised and directed bench for blk_stage_pipe against a queue-of-beats reference model.
module tb_blk_stage_pipe;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int DW    = LANES*WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef BLK_STAGE_PIPE_CNT_EN
  logic [31:0]   beat_count;
  logic [31:0]   m_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: beats in flight, oldest first, with their slot position (DEPTH = result slot)
  logic [WIDTH-1:0] m_val[$];
  int               m_pos[$];
  logic [WIDTH-1:0] m_last;
  bit               started = 0;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;

  always #5 clk = ~clk;

  blk_stage_pipe #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BLK_STAGE_PIPE_CNT_EN
    , .beat_count(beat_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] op(input logic [DW-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r = d[WIDTH-1:0];
    for (int k = 1; k < LANES; k++) begin
      case (m)
        2'b00: r = r & d[k*WIDTH +: WIDTH];
        2'b01: r = r | d[k*WIDTH +: WIDTH];
        2'b10: r = r ^ d[k*WIDTH +: WIDTH];
        default: r = d[WIDTH-1:0];
      endcase
    end
    return r;
  endfunction

  // One clock: drive, check before the edge, then advance the model across the edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [1:0] m,
                       input logic ordy, input logic r);
    logic exp_ready, exp_ov, acc;
    int ahead, np;
    logic [WIDTH-1:0] nv[$];
    int               npos[$];
    @(negedge clk);
    in_valid = iv; in_data = d; mode = m; out_ready = ordy; rst = r;
    #1;
    exp_ready = !r && ((m_val.size() <= DEPTH) || ordy);
    exp_ov    = (m_val.size() > 0) && (m_pos[0] == DEPTH);
    obs_valid = out_valid;
    obs_data  = out_data;
    if (started) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("out_data", {24'd0, out_data}, {24'd0, m_last});
`ifdef BLK_STAGE_PIPE_CNT_EN
      chk("beat_count", beat_count, m_cnt);
`endif
    end
    @(posedge clk);
    if (r) begin
      m_val.delete(); m_pos.delete(); m_last = '0; started = 1;
`ifdef BLK_STAGE_PIPE_CNT_EN
      m_cnt = '0;
`endif
      return;
    end
    acc = iv && exp_ready;
    ahead = DEPTH + 1;
    for (int i = 0; i < m_val.size(); i++) begin
      if (m_pos[i] == DEPTH && ordy) begin
        ahead = DEPTH + 1;
`ifdef BLK_STAGE_PIPE_CNT_EN
        m_cnt++;
`endif
      end else begin
        np = (m_pos[i] < DEPTH && m_pos[i] + 1 < ahead) ? m_pos[i] + 1 : m_pos[i];
        if (np == DEPTH && m_pos[i] != DEPTH) m_last = m_val[i];
        ahead = np;
        nv.push_back(m_val[i]);
        npos.push_back(np);
      end
    end
    if (acc) begin
      nv.push_back(op(d, m));
      npos.push_back(0);
    end
    m_val = nv;
    m_pos = npos;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 2'b00, ordy, 1'b0);
  endtask

  logic [WIDTH-1:0] mode_exp [4];

  initial begin
    mode_exp[0] = 8'h30; mode_exp[1] = 8'hFC; mode_exp[2] = 8'hCC; mode_exp[3] = 8'h3C;
    cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
    cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);

    // single-beat latency and each combine op on 16'hF03C
    for (int m = 0; m < 4; m++) begin
      cycle(1'b1, 16'hF03C, 2'(m), 1'b1, 1'b0);
      idle(1, 1'b1);
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
      chk("lat_early", {31'd0, obs_valid}, 32'd0);
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
      chk("lat_valid", {31'd0, obs_valid}, 32'd1);
      chk("mode_res", {24'd0, obs_data}, {24'd0, mode_exp[m]});
      idle(1, 1'b1);
    end

    // back-to-back streaming
    for (int i = 0; i < 10; i++) cycle(1'b1, {8'(i + 1), 8'(i)}, 2'b10, 1'b1, 1'b0);
    idle(4, 1'b1);

    // backpressure: A,B,C fill, D refused, then drain; then full with simultaneous drain
    for (int i = 0; i < 4; i++) cycle(1'b1, {8'hA0 + 8'(i), 8'h0F}, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, {8'hA3, 8'h0F}, 2'b00, 1'b1, 1'b0);
    chk("bp_full", {29'd0, 3'(m_val.size())}, 32'd3);
    cycle(1'b1, {8'hE0, 8'hFF}, 2'b11, 1'b1, 1'b0);
    chk("full_drain_occ", {29'd0, 3'(m_val.size())}, 32'd3);
    idle(5, 1'b1);

    // mode change between consecutive beats
    cycle(1'b1, 16'h5AF0, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 16'h5AF0, 2'b10, 1'b1, 1'b0);
    idle(4, 1'b1);

    // reset with beats in flight
    cycle(1'b1, 16'h1234, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 16'h5678, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 16'h9ABC, 2'b01, 1'b1, 1'b1);
    idle(4, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end
    idle(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
